reg_window_ctrl: RTL and testbench
==================================

REG_WINDOW_CTRL -- requirements
Module: reg_window_ctrl

Interface
REQ-001 SHALL have parameter NWINDOWS, default 8, number of register windows (power of two, 4..32).
REQ-002 SHALL have parameter XFER_REGS, default 16, registers moved per spill/fill (locals + ins).
REQ-003 SHALL have ports: Clk  in  1  sole clock, rising edge.
REQ-004 Clr  in  1  asynchronous, active-high clear.
REQ-005 save_req  in  1  request CWP decrement (SAVE).
REQ-006 restore_req  in  1  request CWP increment (RESTORE).
REQ-007 wim_load  in  1  load WIM from wim_in; wim_in  in  NWINDOWS  new window-invalid mask.
REQ-008 xfer_ack  in  1  memory side accepted current transfer beat.
REQ-009 cwp  out  log2(NWINDOWS)  current window pointer; wim  out  NWINDOWS  current mask.
REQ-010 xfer_valid  out  1  transfer beat pending; xfer_dir  out  1  0=spill, 1=fill.
REQ-011 xfer_win  out  log2(NWINDOWS)  window being moved; xfer_idx  out  4  register index within window.
REQ-012 busy  out  1  spill/fill in progress; op_done  out  1  one-cycle pulse when cwp updates.

Function
REQ-013 SHALL implement FSM states IDLE, SPILL, FILL; all outputs registered.
REQ-014 IDLE, save_req only: new=(cwp-1) mod NWINDOWS; wim[new]=0 -> cwp<=new, op_done next cycle (1-cycle latency).
REQ-015 IDLE, save_req, wim[new]=1 -> SPILL, xfer_win<=new, xfer_idx<=0, xfer_dir<=0, busy<=1.
REQ-016 IDLE, restore_req only: new=(cwp+1) mod NWINDOWS; wim[new]=0 -> cwp<=new, op_done; wim[new]=1 -> FILL, xfer_win<=new, xfer_dir<=1.
REQ-017 SPILL/FILL: xfer_valid held high until xfer_ack; each xfer_valid&&xfer_ack advances xfer_idx by 1.
REQ-018 Ack on beat XFER_REGS-1 -> IDLE, xfer_valid<=0, busy<=0, cwp<=xfer_win, op_done pulse same edge.
REQ-019 Spill completion SHALL rotate wim right by 1 (invalid bit moves to xfer_win-1 mod N); fill completion rotates left by 1.
REQ-020 xfer_ack while xfer_valid=0 SHALL be ignored.
REQ-021 save_req and restore_req high together in IDLE -> no-op, no state change.
REQ-022 save_req/restore_req while busy SHALL be ignored (not queued).
REQ-023 wim_load in IDLE -> wim<=wim_in; same-cycle save/restore dropped; wim_load while busy ignored.
REQ-024 cwp SHALL wrap: 0 decrements to NWINDOWS-1, NWINDOWS-1 increments to 0.

Reset
REQ-025 Clr high SHALL immediately force: state IDLE, cwp=0, wim=2'b10 (bit 1 only), xfer_valid=0, xfer_idx=0, xfer_win=0, xfer_dir=0, busy=0, op_done=0.
REQ-026 Clr during SPILL/FILL SHALL abort transfer without updating cwp or wim beyond reset values.
REQ-027 First rising Clk after Clr falls SHALL be a normal IDLE cycle.

Configuration
REQ-028 Macro REG_WINDOW_CTRL_STATS_EN defined: extra outputs spill_cnt, fill_cnt (16 bit each, out), increment on each completed spill/fill, saturate at 16'hFFFF, cleared by Clr.
REQ-029 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-030 Package reg_window_pkg SHALL hold FSM state enum, XFER_REGS default, xfer_dir encodings.
REQ-031 Sub-module window_xfer_seq SHALL contain the xfer_idx counter and valid/ack handshake (start, done, idx).

Verification
REQ-032 Clr pulse -> cwp=0, wim=8'h02, busy=0, xfer_valid=0 with Clk stopped.
REQ-033 From reset, 6 saves -> cwp 7,6,5,4,3,2 each 1 cycle, 6 op_done pulses; 7th save -> SPILL, xfer_win=1.
REQ-034 SPILL with xfer_ack every other cycle -> xfer_idx 0..15 each held until ack; after 16th ack cwp=1, wim=8'h01, busy=0.
REQ-035 cwp=0, wim=8'h02, restore -> FILL xfer_win=1; 16 acks -> cwp=1, wim=8'h04.
REQ-036 save_req+restore_req together, and save_req during SPILL -> cwp, state unchanged; Clr at xfer_idx=7 -> all reset values.
REQ-037 With REG_WINDOW_CTRL_STATS_EN: two spills, one fill -> spill_cnt=2, fill_cnt=1.

Source files
------------

// File: rtl/reg_window_pkg.sv
// rtl/reg_window_pkg.sv - shared types and constants for the register window controller
package reg_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPILL = 2'd1,
    ST_FILL  = 2'd2
  } win_state_t;

  localparam int XFER_REGS_DEF = 16;

  localparam logic XFER_DIR_SPILL = 1'b0;
  localparam logic XFER_DIR_FILL  = 1'b1;

endpackage

// File: rtl/window_xfer_seq.sv
// rtl/window_xfer_seq.sv - beat sequencer for one spill/fill: valid/ack handshake and register index
module window_xfer_seq
  import reg_window_pkg::*;
#(
  parameter int XFER_REGS = XFER_REGS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ack,
  output logic       valid,
  output logic [3:0] idx,
  output logic       done
);

  logic       valid_q, valid_d;
  logic [3:0] idx_q, idx_d;
  logic       beat;

  assign beat = valid_q && ack;
  assign done = beat && (idx_q == 4'(XFER_REGS - 1));

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    if (start) begin
      valid_d = 1'b1;
      idx_d   = 4'd0;
    end else if (done) begin
      valid_d = 1'b0;
      idx_d   = 4'd0;
    end else if (beat) begin
      idx_d = idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= 4'd0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign valid = valid_q;
  assign idx   = idx_q;

endmodule

// File: rtl/reg_window_ctrl.sv
// rtl/reg_window_ctrl.sv - register window pointer/mask controller with spill/fill sequencing
// Optional spill/fill counters are built when REG_WINDOW_CTRL_STATS_EN is defined.
module reg_window_ctrl
  import reg_window_pkg::*;
#(
  parameter int NWINDOWS  = 8,
  parameter int XFER_REGS = XFER_REGS_DEF
) (
  input  logic                        Clk,
  input  logic                        Clr,
  input  logic                        save_req,
  input  logic                        restore_req,
  input  logic                        wim_load,
  input  logic [NWINDOWS-1:0]         wim_in,
  input  logic                        xfer_ack,
  output logic [$clog2(NWINDOWS)-1:0] cwp,
  output logic [NWINDOWS-1:0]         wim,
  output logic                        xfer_valid,
  output logic                        xfer_dir,
  output logic [$clog2(NWINDOWS)-1:0] xfer_win,
  output logic [3:0]                  xfer_idx,
  output logic                        busy,
  output logic                        op_done
`ifdef REG_WINDOW_CTRL_STATS_EN
  ,
  output logic [15:0]                 spill_cnt,
  output logic [15:0]                 fill_cnt
`endif
);

  localparam int CW = $clog2(NWINDOWS);
  localparam logic [NWINDOWS-1:0] WIM_RESET = NWINDOWS'(2);

  win_state_t          state_q, state_d;
  logic [CW-1:0]       cwp_q, cwp_d;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic [CW-1:0]       xfer_win_q, xfer_win_d;
  logic                xfer_dir_q, xfer_dir_d;
  logic                busy_q, busy_d;
  logic                op_done_q, op_done_d;
  logic                seq_start, seq_done;
  logic [CW-1:0]       save_win, rest_win;

  assign save_win = cwp_q - CW'(1);
  assign rest_win = cwp_q + CW'(1);

  window_xfer_seq #(.XFER_REGS(XFER_REGS)) u_seq (
    .clk   (Clk),
    .rst   (Clr),
    .start (seq_start),
    .ack   (xfer_ack),
    .valid (xfer_valid),
    .idx   (xfer_idx),
    .done  (seq_done)
  );

  always_comb begin
    state_d    = state_q;
    cwp_d      = cwp_q;
    wim_d      = wim_q;
    xfer_win_d = xfer_win_q;
    xfer_dir_d = xfer_dir_q;
    busy_d     = busy_q;
    op_done_d  = 1'b0;
    seq_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wim_load) begin
          wim_d = wim_in;
        end else if (save_req && !restore_req) begin
          if (wim_q[save_win]) begin
            state_d    = ST_SPILL;
            xfer_win_d = save_win;
            xfer_dir_d = XFER_DIR_SPILL;
            busy_d     = 1'b1;
            seq_start  = 1'b1;
          end else begin
            cwp_d     = save_win;
            op_done_d = 1'b1;
          end
        end else if (restore_req && !save_req) begin
          if (wim_q[rest_win]) begin
            state_d    = ST_FILL;
            xfer_win_d = rest_win;
            xfer_dir_d = XFER_DIR_FILL;
            busy_d     = 1'b1;
            seq_start  = 1'b1;
          end else begin
            cwp_d     = rest_win;
            op_done_d = 1'b1;
          end
        end
      end
      default: begin
        // The invalid marker follows the moved window: right after a spill, left after a fill.
        if (seq_done) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          cwp_d     = xfer_win_q;
          op_done_d = 1'b1;
          if (state_q == ST_SPILL) wim_d = {wim_q[0], wim_q[NWINDOWS-1:1]};
          else                     wim_d = {wim_q[NWINDOWS-2:0], wim_q[NWINDOWS-1]};
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q    <= ST_IDLE;
      cwp_q      <= '0;
      wim_q      <= WIM_RESET;
      xfer_win_q <= '0;
      xfer_dir_q <= XFER_DIR_SPILL;
      busy_q     <= 1'b0;
      op_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cwp_q      <= cwp_d;
      wim_q      <= wim_d;
      xfer_win_q <= xfer_win_d;
      xfer_dir_q <= xfer_dir_d;
      busy_q     <= busy_d;
      op_done_q  <= op_done_d;
    end
  end

  assign cwp      = cwp_q;
  assign wim      = wim_q;
  assign xfer_win = xfer_win_q;
  assign xfer_dir = xfer_dir_q;
  assign busy     = busy_q;
  assign op_done  = op_done_q;

`ifdef REG_WINDOW_CTRL_STATS_EN
  logic [15:0] spill_cnt_q, spill_cnt_d;
  logic [15:0] fill_cnt_q, fill_cnt_d;

  always_comb begin
    spill_cnt_d = spill_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    if (seq_done && state_q == ST_SPILL && spill_cnt_q != 16'hFFFF) spill_cnt_d = spill_cnt_q + 16'd1;
    if (seq_done && state_q == ST_FILL  && fill_cnt_q  != 16'hFFFF) fill_cnt_d  = fill_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      spill_cnt_q <= 16'd0;
      fill_cnt_q  <= 16'd0;
    end else begin
      spill_cnt_q <= spill_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
    end
  end

  assign spill_cnt = spill_cnt_q;
  assign fill_cnt  = fill_cnt_q;
`endif

endmodule

// File: tb/tb_reg_window_ctrl.sv
// tb/tb_reg_window_ctrl.sv - directed self-checking bench for reg_window_ctrl (NWINDOWS=8, XFER_REGS=16)
module tb_reg_window_ctrl;

  logic       Clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       Clr = 1'b0;
  logic       save_req = 1'b0;
  logic       restore_req = 1'b0;
  logic       wim_load = 1'b0;
  logic [7:0] wim_in = 8'h00;
  logic       xfer_ack = 1'b0;
  logic [2:0] cwp;
  logic [7:0] wim;
  logic       xfer_valid;
  logic       xfer_dir;
  logic [2:0] xfer_win;
  logic [3:0] xfer_idx;
  logic       busy;
  logic       op_done;
`ifdef REG_WINDOW_CTRL_STATS_EN
  logic [15:0] spill_cnt;
  logic [15:0] fill_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt;

  reg_window_ctrl dut (
    .Clk         (Clk),
    .Clr         (Clr),
    .save_req    (save_req),
    .restore_req (restore_req),
    .wim_load    (wim_load),
    .wim_in      (wim_in),
    .xfer_ack    (xfer_ack),
    .cwp         (cwp),
    .wim         (wim),
    .xfer_valid  (xfer_valid),
    .xfer_dir    (xfer_dir),
    .xfer_win    (xfer_win),
    .xfer_idx    (xfer_idx),
    .busy        (busy),
    .op_done     (op_done)
`ifdef REG_WINDOW_CTRL_STATS_EN
    ,
    .spill_cnt   (spill_cnt),
    .fill_cnt    (fill_cnt)
`endif
  );

  always begin
    #5;
    if (clk_en) Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_clr();
    #2 Clr = 1'b1;
    #1 Clr = 1'b0;
  endtask

  task automatic run_xfer(input logic is_save);
    save_req    = is_save;
    restore_req = !is_save;
    step();
    save_req    = 1'b0;
    restore_req = 1'b0;
    xfer_ack    = 1'b1;
    repeat (16) step();
    xfer_ack    = 1'b0;
  endtask

  initial begin
    // Clear with clock stopped
    #5 Clr = 1'b1;
    #1;
    chk("rst_cwp", cwp, 0);
    chk("rst_wim", wim, 8'h02);
    chk("rst_busy", busy, 0);
    chk("rst_valid", xfer_valid, 0);
    chk("rst_idx", xfer_idx, 0);
    chk("rst_op_done", op_done, 0);
    #4 Clr = 1'b0;
    clk_en = 1'b1;

    // Six free saves, then a spill of window 1
    save_req = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("save_cwp", cwp, 7 - i);
      if (op_done) done_cnt++;
    end
    chk("save_done_cnt", done_cnt, 6);
    step();
    chk("spill_busy", busy, 1);
    chk("spill_valid", xfer_valid, 1);
    chk("spill_win", xfer_win, 1);
    chk("spill_dir", xfer_dir, 0);
    chk("spill_cwp_hold", cwp, 2);
    chk("spill_no_done", op_done, 0);

    for (int k = 0; k < 16; k++) begin
      if (k == 2) save_req = 1'b0;
      chk("spill_idx", xfer_idx, k);
      step();
      chk("spill_idx_held", xfer_idx, k);
      chk("spill_cwp_busy", cwp, 2);
      xfer_ack = 1'b1;
      step();
      xfer_ack = 1'b0;
    end
    chk("spill_end_cwp", cwp, 1);
    chk("spill_end_wim", wim, 8'h01);
    chk("spill_end_busy", busy, 0);
    chk("spill_end_valid", xfer_valid, 0);
    chk("spill_end_done", op_done, 1);
    xfer_ack = 1'b1;
    step();
    xfer_ack = 1'b0;
    chk("stray_ack_cwp", cwp, 1);
    chk("stray_ack_busy", busy, 0);
    chk("done_one_cycle", op_done, 0);

    // Fill of window 1 from reset state
    pulse_clr();
    restore_req = 1'b1;
    step();
    restore_req = 1'b0;
    chk("fill_busy", busy, 1);
    chk("fill_win", xfer_win, 1);
    chk("fill_dir", xfer_dir, 1);
    xfer_ack = 1'b1;
    repeat (15) step();
    chk("fill_idx15", xfer_idx, 15);
    chk("fill_busy15", busy, 1);
    step();
    xfer_ack = 1'b0;
    chk("fill_end_cwp", cwp, 1);
    chk("fill_end_wim", wim, 8'h04);
    chk("fill_end_busy", busy, 0);
    chk("fill_end_done", op_done, 1);

    // Simultaneous save/restore is a no-op
    save_req = 1'b1;
    restore_req = 1'b1;
    step();
    save_req = 1'b0;
    restore_req = 1'b0;
    chk("both_cwp", cwp, 1);
    chk("both_busy", busy, 0);
    chk("both_done", op_done, 0);

    // WIM load wins over a same-cycle save
    wim_in = 8'h10;
    wim_load = 1'b1;
    save_req = 1'b1;
    step();
    wim_load = 1'b0;
    chk("load_wim", wim, 8'h10);
    chk("load_cwp", cwp, 1);
    chk("load_done", op_done, 0);
    step();
    chk("save_to0", cwp, 0);
    step();
    chk("save_wrap", cwp, 7);
    save_req = 1'b0;
    restore_req = 1'b1;
    step();
    restore_req = 1'b0;
    chk("restore_wrap", cwp, 0);
    chk("restore_done", op_done, 1);

    // Abort a spill with Clr mid-transfer
    wim_in = 8'h80;
    wim_load = 1'b1;
    step();
    wim_load = 1'b0;
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    chk("abort_win", xfer_win, 7);
    xfer_ack = 1'b1;
    repeat (7) step();
    chk("abort_idx7", xfer_idx, 7);
    pulse_clr();
    xfer_ack = 1'b0;
    chk("abort_cwp", cwp, 0);
    chk("abort_wim", wim, 8'h02);
    chk("abort_busy", busy, 0);
    chk("abort_valid", xfer_valid, 0);
    chk("abort_idx", xfer_idx, 0);
    chk("abort_xwin", xfer_win, 0);
    chk("abort_dir", xfer_dir, 0);

    // First edge after Clr is a normal IDLE cycle; WIM load while busy is ignored
    restore_req = 1'b1;
    step();
    restore_req = 1'b0;
    chk("post_clr_fill", busy, 1);
    wim_in = 8'hFF;
    wim_load = 1'b1;
    step();
    wim_load = 1'b0;
    chk("busy_load_ign", wim, 8'h02);
    pulse_clr();

    // Two spills and one fill for the counters
    run_xfer(1'b0);
    chk("seq_fill_cwp", cwp, 1);
    wim_in = 8'h01;
    wim_load = 1'b1;
    step();
    wim_load = 1'b0;
    run_xfer(1'b1);
    chk("seq_spill1_cwp", cwp, 0);
    chk("seq_spill1_wim", wim, 8'h80);
    run_xfer(1'b1);
    chk("seq_spill2_cwp", cwp, 7);
    chk("seq_spill2_wim", wim, 8'h40);
`ifdef REG_WINDOW_CTRL_STATS_EN
    chk("spill_cnt", spill_cnt, 2);
    chk("fill_cnt", fill_cnt, 1);
    pulse_clr();
    chk("spill_cnt_clr", spill_cnt, 0);
    chk("fill_cnt_clr", fill_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
